// File: rtl/ttt_dot_render_pkg.sv
// Shared tic-tac-toe definitions: cell encoding, board/matrix geometry and
// small helpers used by the dot-matrix renderer.
package ttt_dot_render_pkg;

    localparam int unsigned BOARD_W  = 18;
    localparam int unsigned DOT_ROWS = 10;
    localparam int unsigned DOT_COLS = 14;
    localparam int unsigned CELLS    = 9;
    localparam int unsigned LAST_ROW = 9;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10,
        CELL_BLANK = 2'b11
    } cell_e;

    typedef struct packed {
        logic [BOARD_W-1:0] board;
        logic               turn;
        logic [CELLS-1:0]   win;
    } snap_t;

    // Glyph lines are MSB-leftmost, but column 0 is the matrix's left edge.
    function automatic logic [2:0] rev3(input logic [2:0] p);
        return {p[0], p[1], p[2]};
    endfunction

    function automatic logic [DOT_COLS-1:0] status_bar(input logic turn,
                                                       input logic [CELLS-1:0] win,
                                                       input logic blink);
        if (win != '0)
            return blink ? '0 : '1;
        return turn ? {6'h3F, 8'h00} : {8'h00, 6'h3F};
    endfunction

endpackage

// File: rtl/ttt_dot_render_glyph.sv
// One 3-dot line of a cell glyph (X, O or blank) for a given glyph line.
module ttt_glyph
    import ttt_dot_render_pkg::*;
(
    input  logic [1:0] cell_i,
    input  logic [1:0] line_i,
    input  logic       hide_i,
    output logic [2:0] pat_o
);

    always_comb begin
        pat_o = '0;
        if (!hide_i) begin
            case (cell_e'(cell_i))
                CELL_X:  pat_o = (line_i == 2'd1) ? 3'b010 : 3'b101;
                CELL_O:  pat_o = (line_i == 2'd1) ? 3'b101 : 3'b111;
                default: pat_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/ttt_dot_render.sv
// Row-multiplexed renderer for the 10x14 dot matrix: board glyphs, turn
// indicator and blinking winning line, frame-snapshotted to avoid tearing.
module ttt_dot_render
    import ttt_dot_render_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 12499,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [BOARD_W-1:0]  board,
    input  logic                turn_o,
    input  logic [CELLS-1:0]    win_mask,
    output logic [DOT_ROWS-1:0] dot_row,
    output logic [DOT_COLS-1:0] dot_col
);

    localparam int unsigned PW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]       pre_q, pre_d;
    logic [3:0]          row_q, row_d;
    logic [FW-1:0]       frm_q, frm_d;
    logic                blink_q, blink_d;
    snap_t               snap_q, snap_d, live, src;
    logic [DOT_ROWS-1:0] drow_q, drow_d;
    logic [DOT_COLS-1:0] dcol_q, dcol_d;
    logic                tick, frame_start;

    logic [1:0]          line;
    logic [5:0]          row_cells;
    logic [2:0]          row_win;
    logic [2:0]          pat [3];

    assign live        = {board, turn_o, win_mask};
    assign tick        = (pre_q == PW'(SCAN_DIV));
    assign frame_start = tick && (row_q == 4'(LAST_ROW));

    always_comb begin
        pre_d   = tick ? '0 : pre_q + PW'(1);
        row_d   = row_q;
        frm_d   = frm_q;
        blink_d = blink_q;
        snap_d  = snap_q;
        if (tick)
            row_d = (row_q == 4'(LAST_ROW)) ? '0 : row_q + 4'd1;
        if (frame_start) begin
            snap_d = live;
            if (frm_q == FW'(BLINK_FRAMES - 1)) begin
                frm_d   = '0;
                blink_d = ~blink_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end
    end

    // Row 0 is built from the inputs being captured on this very tick.
    assign src = frame_start ? live : snap_q;

    always_comb begin
        if (row_d < 4'd3) begin
            line      = row_d[1:0];
            row_cells = src.board[5:0];
            row_win   = src.win[2:0];
        end else if (row_d < 4'd6) begin
            line      = 2'(row_d - 4'd3);
            row_cells = src.board[11:6];
            row_win   = src.win[5:3];
        end else begin
            line      = 2'(row_d - 4'd6);
            row_cells = src.board[17:12];
            row_win   = src.win[8:6];
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_cell
        ttt_glyph u_glyph (
            .cell_i (row_cells[2*g +: 2]),
            .line_i (line),
            .hide_i (row_win[g] & blink_d),
            .pat_o  (pat[g])
        );
    end

    always_comb begin
        drow_d = DOT_ROWS'(1) << row_d;
        if (row_d == 4'(LAST_ROW))
            dcol_d = status_bar(src.turn, src.win, blink_d);
        else
            dcol_d = {2'b00, 1'b0, rev3(pat[2]), 1'b0, rev3(pat[1]), 1'b0, rev3(pat[0])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            row_q   <= 4'(LAST_ROW);
            frm_q   <= '0;
            blink_q <= 1'b0;
            snap_q  <= '0;
            drow_q  <= '0;
            dcol_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            row_q   <= row_d;
            frm_q   <= frm_d;
            blink_q <= blink_d;
            snap_q  <= snap_d;
            if (!enable) begin
                drow_q <= '0;
                dcol_q <= '0;
            end else if (tick) begin
                drow_q <= drow_d;
                dcol_q <= dcol_d;
            end
        end
    end

    assign dot_row = drow_q;
    assign dot_col = dcol_q;

endmodule

// File: tb/tb_ttt_dot_render.sv
// Self-checking bench for ttt_dot_render against a frame-level behavioural model.
module tb_ttt_dot_render;

    localparam int SD = 3;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [17:0] board;
    logic        turn_o;
    logic [8:0]  win_mask;
    logic [9:0]  dot_row;
    logic [13:0] dot_col;

    always #5 clk = ~clk;

    ttt_dot_render #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .board    (board),
        .turn_o   (turn_o),
        .win_mask (win_mask),
        .dot_row  (dot_row),
        .dot_col  (dot_col)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Image the matrix must show for a given row, straight from the display rules.
    function automatic logic [13:0] render(input int row, input logic [17:0] b,
                                           input logic t, input logic [8:0] w, input bit blk);
        logic [13:0] r;
        logic [2:0]  g;
        logic [1:0]  cv;
        int          k;
        r = '0;
        if (row == 9) begin
            if (w != 0) r = blk ? 14'h0 : 14'h3FFF;
            else for (int j = 0; j < 6; j++) r[t ? 8 + j : j] = 1'b1;
        end else begin
            for (int c = 0; c < 3; c++) begin
                k  = 3 * (row / 3) + c;
                cv = b[2*k +: 2];
                if (cv == 2'b01)      g = (row % 3 == 1) ? 3'b010 : 3'b101;
                else if (cv == 2'b10) g = (row % 3 == 1) ? 3'b101 : 3'b111;
                else                  g = 3'b000;
                if (w[k] && blk) g = 3'b000;
                for (int j = 0; j < 3; j++) r[4*c + j] = g[2-j];
            end
        end
        return r;
    endfunction

    bit          m_valid = 0;
    bit          m_tick  = 0;
    int          m_n, m_t, m_row, m_f;
    logic [17:0] f_board;
    logic        f_turn;
    logic [8:0]  f_win;
    logic [9:0]  e_row;
    logic [13:0] e_col;

    // Model: edges since reset -> tick number -> row and frame index.
    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_n = 0; m_t = 0; m_tick = 0; m_row = 9;
            f_board = '0; f_turn = 1'b0; f_win = '0;
            e_row = '0; e_col = '0;
        end else if (m_valid) begin
            m_tick = (m_n % (SD + 1)) == SD;
            m_n++;
            if (m_tick) begin
                m_row = m_t % 10;
                m_f   = m_t / 10;
                if (m_row == 0) begin
                    f_board = board; f_turn = turn_o; f_win = win_mask;
                end
                m_t++;
            end
            if (!enable) begin
                e_row = '0; e_col = '0;
            end else if (m_tick) begin
                e_row = 10'd1 << m_row;
                e_col = render(m_row, f_board, f_turn, f_win, (((m_f + 1) / BF) % 2) == 1);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_row", dot_row, e_row);
            check("cyc_col", dot_col, e_col);
        end
    end

    task automatic sync_row(input int r);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_tick && m_row == r) return;
        end
        tests++;
        fails++;
        $display("FAIL sync_row%0d: got timeout expected tick within 400 cycles", r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [13:0] r0 [6];
    logic [13:0] r9 [6];
    bit          shown [6];
    int          nshown;

    initial begin
        rst = 1'b1; enable = 1'b1; turn_o = 1'b0; win_mask = '0;
        board = 18'b00_00_00_00_00_00_00_00_01;

        repeat (3) @(negedge clk);
        check("rst_row", dot_row, 0);
        check("rst_col", dot_col, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_tick_row", dot_row, 0);
        @(negedge clk);
        check("first_tick_row", dot_row, 10'b0000000001);
        check("x_row0", dot_col, 14'b00000000000101);
        sync_row(1); check("x_row1", dot_col, 14'b00000000000010);
        sync_row(2); check("x_row2", dot_col, 14'b00000000000101);
        sync_row(9); check("x_row9", dot_col, 14'b00000000111111);

        board  = 18'b10_00_00_00_00_00_00_00_01;
        turn_o = 1'b1;
        sync_row(0);
        sync_row(6); check("o_row6", dot_col, 14'b00011100000000);
        sync_row(7); check("o_row7", dot_col, 14'b00010100000000);
        sync_row(8); check("o_row8", dot_col, 14'b00011100000000);
        sync_row(9); check("o_row9", dot_col, 14'b11111100000000);

        sync_row(4);
        board  = 18'b01_00_00_00_00_00_00_00_01;
        turn_o = 1'b0;
        sync_row(6); check("tear_row6_old", dot_col, 14'b00011100000000);
        sync_row(9); check("tear_row9_old", dot_col, 14'b11111100000000);
        sync_row(6); check("tear_row6_new", dot_col, 14'b00010100000000);
        sync_row(9); check("tear_row9_new", dot_col, 14'b00000000111111);

        board    = 18'b00_00_00_00_00_00_01_01_01;
        win_mask = 9'b000000111;
        for (int f = 0; f < 6; f++) begin
            sync_row(0); r0[f] = dot_col;
            sync_row(9); r9[f] = dot_col;
        end
        nshown = 0;
        for (int f = 0; f < 6; f++) begin
            shown[f] = (r0[f] != 14'h0);
            check("blink_row0_val", r0[f], shown[f] ? 14'b00010101010101 : 14'h0);
            check("blink_row9_val", r9[f], shown[f] ? 14'h3FFF : 14'h0);
        end
        for (int f = 0; f < 4; f++) begin
            check("blink_period", shown[f] != shown[f+2], 1);
            if (shown[f]) nshown++;
        end
        check("blink_duty", nshown, 2);

        win_mask = '0;
        sync_row(3);
        enable = 1'b0;
        @(negedge clk);
        check("dis_row", dot_row, 0);
        check("dis_col", dot_col, 0);
        repeat (9) @(negedge clk);
        check("dis_hold_row", dot_row, 0);
        enable = 1'b1;
        sync_row(5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_row", dot_row, 0);
        check("midrst_col", dot_col, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_next_row0", dot_row, 10'b0000000001);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(499) == 0) rst = 1'b1;
            if ($urandom_range(99) == 0) enable = ~enable;
            if ($urandom_range(39) == 0) begin
                board    = 18'($urandom);
                turn_o   = 1'($urandom);
                win_mask = $urandom_range(1) ? 9'($urandom) : 9'h0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
